// File: rtl/ace_ccu_snoop_sched_if.sv
// Bus bundle between the CCU coherency scheduler and its ACE ports / datapath.
// Port-indexed fields are packed as [port][field].
interface ace_ccu_snoop_sched_if #(
    parameter int unsigned NoPorts   = 4,
    parameter int unsigned AddrWidth = 64
);
    localparam int unsigned IdxW = (NoPorts > 1) ? $clog2(NoPorts) : 1;

    logic [NoPorts-1:0]                req_valid_i;
    logic [NoPorts-1:0]                req_ready_o;
    logic [NoPorts-1:0][2:0]           req_trs_i;
    logic [NoPorts-1:0][AddrWidth-1:0] req_addr_i;
    logic [NoPorts-1:0]                snp_valid_o;
    logic [NoPorts-1:0]                snp_ready_i;
    logic [AddrWidth-1:0]              snp_addr_o;
    logic [3:0]                        snp_type_o;
    logic [NoPorts-1:0]                cr_valid_i;
    logic [NoPorts-1:0]                cr_ready_o;
    logic [NoPorts-1:0][4:0]           cr_resp_i;
    logic                              dec_valid_o;
    logic                              dec_ready_i;
    logic [IdxW-1:0]                   dec_idx_o;
    logic [2:0]                        dec_trs_o;
    logic [AddrWidth-1:0]              dec_addr_o;
    logic                              dec_from_snp_o;
    logic [IdxW-1:0]                   dec_src_o;
    logic                              dec_dirty_o;
    logic                              dec_shared_o;
    logic                              dec_err_o;
    logic                              busy_o;

    modport slave (
        input  req_valid_i, req_trs_i, req_addr_i, snp_ready_i, cr_valid_i, cr_resp_i,
               dec_ready_i,
        output req_ready_o, snp_valid_o, snp_addr_o, snp_type_o, cr_ready_o, dec_valid_o,
               dec_idx_o, dec_trs_o, dec_addr_o, dec_from_snp_o, dec_src_o, dec_dirty_o,
               dec_shared_o, dec_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_trs_i, req_addr_i, snp_ready_i, cr_valid_i, cr_resp_i,
               dec_ready_i,
        input  req_ready_o, snp_valid_o, snp_addr_o, snp_type_o, cr_ready_o, dec_valid_o,
               dec_idx_o, dec_trs_o, dec_addr_o, dec_from_snp_o, dec_src_o, dec_dirty_o,
               dec_shared_o, dec_err_o, busy_o
    );
endinterface

// File: rtl/ace_ccu_snoop_sched.sv
// CCU coherency scheduler: round-robin request grant, AC snoop broadcast, CR collection,
// one decision record per transaction. Only one transaction is in flight at a time.
module ace_ccu_snoop_sched #(
    parameter int unsigned NoPorts   = 4,
    parameter int unsigned AddrWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ace_ccu_snoop_sched_if.slave bus
);
    localparam int unsigned IdxW = (NoPorts > 1) ? $clog2(NoPorts) : 1;

    typedef enum logic [1:0] {IDLE, SNOOP, DECIDE} state_e;

    // ace_trs_t encoding
    typedef enum logic [2:0] {
        TRS_READ_NO_SNOOP  = 3'd0, TRS_READ_ONCE    = 3'd1, TRS_READ_SHARED    = 3'd2,
        TRS_READ_UNIQUE    = 3'd3, TRS_CLEAN_UNIQUE = 3'd4, TRS_WRITE_NO_SNOOP = 3'd5,
        TRS_WRITE_BACK     = 3'd6, TRS_WRITE_UNIQUE = 3'd7
    } trs_e;

    state_e               r_state, w_state_n;
    logic [IdxW-1:0]      r_ptr, r_idx, r_src, w_src_n, w_gnt;
    logic [2:0]           r_trs, w_req_trs;
    logic [AddrWidth-1:0] r_addr;
    logic [NoPorts-1:0]   r_tgt, r_ac_done, r_cr_done, w_tgt_mask;
    logic                 r_from_snp, r_dirty, r_shared, r_err;
    logic                 w_from_n, w_dirty_n, w_shared_n, w_err_n;
    logic                 w_gnt_vld, w_no_snp, w_req_hs, w_dec_hs, w_dec_valid;
    logic [NoPorts-1:0]   w_req_ready, w_snp_valid, w_cr_ready, w_ac_hs, w_cr_hs;
    logic [3:0]           w_snp_type;
    logic                 w_unused;

    always_comb begin
        int unsigned k;
        k         = 0;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int unsigned i = 0; i < NoPorts; i++) begin
            k = (32'(r_ptr) + i) % NoPorts;
            if (!w_gnt_vld && bus.req_valid_i[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = IdxW'(k);
            end
        end
    end

    assign w_req_trs = bus.req_trs_i[w_gnt];
    assign w_no_snp  = (w_req_trs == TRS_READ_NO_SNOOP) || (w_req_trs == TRS_WRITE_NO_SNOOP) ||
                       (w_req_trs == TRS_WRITE_BACK);

    always_comb begin
        w_tgt_mask        = '1;
        w_tgt_mask[w_gnt] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_n;
    end

    // req_ready is gated by rst_ni so every output is 0 while reset is asserted.
    always_comb begin
        w_state_n   = r_state;
        w_req_ready = '0;
        w_snp_valid = '0;
        w_cr_ready  = '0;
        w_dec_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld && rst_ni) begin
                    w_req_ready[w_gnt] = 1'b1;
                    w_state_n          = w_no_snp ? DECIDE : SNOOP;
                end
            end
            SNOOP: begin
                w_snp_valid = r_tgt & ~r_ac_done;
                w_cr_ready  = r_tgt & r_ac_done & ~r_cr_done;
                if ((r_cr_done | (w_cr_ready & bus.cr_valid_i)) == r_tgt) w_state_n = DECIDE;
            end
            DECIDE: begin
                w_dec_valid = 1'b1;
                if (bus.dec_ready_i) w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign w_req_hs = |w_req_ready;
    assign w_ac_hs  = w_snp_valid & bus.snp_ready_i;
    assign w_cr_hs  = w_cr_ready & bus.cr_valid_i;
    assign w_dec_hs = w_dec_valid & bus.dec_ready_i;

    // Lowest-index DataTransfer responder wins even when responses arrive out of order.
    always_comb begin
        w_from_n   = r_from_snp;
        w_src_n    = r_src;
        w_dirty_n  = r_dirty;
        w_shared_n = r_shared;
        w_err_n    = r_err;
        for (int unsigned j = 0; j < NoPorts; j++) begin
            if (w_cr_hs[j]) begin
                w_dirty_n  = w_dirty_n  | bus.cr_resp_i[j][2];
                w_shared_n = w_shared_n | bus.cr_resp_i[j][3];
                w_err_n    = w_err_n    | bus.cr_resp_i[j][1];
                if (bus.cr_resp_i[j][0] && (!w_from_n || (IdxW'(j) < w_src_n))) begin
                    w_from_n = 1'b1;
                    w_src_n  = IdxW'(j);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_trs      <= '0;
            r_addr     <= '0;
            r_tgt      <= '0;
            r_ac_done  <= '0;
            r_cr_done  <= '0;
            r_from_snp <= 1'b0;
            r_src      <= '0;
            r_dirty    <= 1'b0;
            r_shared   <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_req_hs) begin
            r_ptr      <= (32'(w_gnt) == NoPorts - 1) ? '0 : w_gnt + 1'b1;
            r_idx      <= w_gnt;
            r_trs      <= w_req_trs;
            r_addr     <= bus.req_addr_i[w_gnt];
            r_tgt      <= w_no_snp ? '0 : w_tgt_mask;
            r_ac_done  <= '0;
            r_cr_done  <= '0;
            r_from_snp <= 1'b0;
            r_src      <= '0;
            r_dirty    <= 1'b0;
            r_shared   <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_dec_hs) begin
            r_tgt      <= '0;
            r_ac_done  <= '0;
            r_cr_done  <= '0;
            r_from_snp <= 1'b0;
            r_src      <= '0;
            r_dirty    <= 1'b0;
            r_shared   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ac_done  <= r_ac_done | w_ac_hs;
            r_cr_done  <= r_cr_done | w_cr_hs;
            r_from_snp <= w_from_n;
            r_src      <= w_src_n;
            r_dirty    <= w_dirty_n;
            r_shared   <= w_shared_n;
            r_err      <= w_err_n;
        end
    end

    always_comb begin
        case (r_trs)
            TRS_READ_SHARED:                    w_snp_type = 4'b0001;
            TRS_READ_UNIQUE:                    w_snp_type = 4'b0111;
            TRS_CLEAN_UNIQUE, TRS_WRITE_UNIQUE: w_snp_type = 4'b1001;
            default:                            w_snp_type = 4'b0000;
        endcase
    end

    // WasUnique carries no weight in the decision.
    always_comb begin
        w_unused = 1'b0;
        for (int unsigned j = 0; j < NoPorts; j++) w_unused = w_unused ^ bus.cr_resp_i[j][4];
    end

    assign bus.req_ready_o    = w_req_ready;
    assign bus.snp_valid_o    = w_snp_valid;
    assign bus.snp_addr_o     = r_addr;
    assign bus.snp_type_o     = w_snp_type;
    assign bus.cr_ready_o     = w_cr_ready;
    assign bus.dec_valid_o    = w_dec_valid;
    assign bus.dec_idx_o      = r_idx;
    assign bus.dec_trs_o      = r_trs;
    assign bus.dec_addr_o     = r_addr;
    assign bus.dec_from_snp_o = r_from_snp;
    assign bus.dec_src_o      = r_src;
    assign bus.dec_dirty_o    = r_dirty;
    assign bus.dec_shared_o   = r_shared;
    assign bus.dec_err_o      = r_err;
    assign bus.busy_o         = (r_state != IDLE);
endmodule

// File: tb/tb_ace_ccu_snoop_sched.sv
// Directed bench for ace_ccu_snoop_sched: table of single transactions plus hand sequences
// for round-robin fairness, a stalled AC channel and reset during a snoop.
module tb_ace_ccu_snoop_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ace_ccu_snoop_sched_if #(.NoPorts(4), .AddrWidth(64)) bus ();
    ace_ccu_snoop_sched #(.NoPorts(4), .AddrWidth(64)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int              port;
        logic [2:0]      trs;
        logic [63:0]     addr;
        logic [3:0][4:0] cr;
        logic [3:0]      e_snp;
        logic [3:0]      e_type;
        int              e_lat;
        logic            e_from;
        logic [1:0]      e_src;
        logic            e_dirty;
        logic            e_shared;
        logic            e_err;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int   n;
        logic got;
        bus.cr_resp_i             = v.cr;
        bus.req_trs_i[v.port]     = v.trs;
        bus.req_addr_i[v.port]    = v.addr;
        bus.req_valid_i           = 4'b0001 << v.port;
        #1;
        chk($sformatf("v%0d req_ready", id), 64'(bus.req_ready_o), 64'(4'b0001 << v.port));
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            cyc();
            n++;
            if (n == 1) begin
                chk($sformatf("v%0d snp_valid", id), 64'(bus.snp_valid_o), 64'(v.e_snp));
                if (v.e_snp != 4'b0000) begin
                    chk($sformatf("v%0d snp_type", id), 64'(bus.snp_type_o), 64'(v.e_type));
                    chk($sformatf("v%0d snp_addr", id), bus.snp_addr_o, v.addr);
                end
            end
            if (bus.dec_valid_o) got = 1'b1;
        end
        chk($sformatf("v%0d latency", id), 64'(n), 64'(v.e_lat));
        if (got) begin
            chk($sformatf("v%0d dec_idx", id), 64'(bus.dec_idx_o), 64'(v.port));
            chk($sformatf("v%0d dec_trs", id), 64'(bus.dec_trs_o), 64'(v.trs));
            chk($sformatf("v%0d dec_addr", id), bus.dec_addr_o, v.addr);
            chk($sformatf("v%0d from_snp", id), 64'(bus.dec_from_snp_o), 64'(v.e_from));
            chk($sformatf("v%0d src", id), 64'(bus.dec_src_o), 64'(v.e_src));
            chk($sformatf("v%0d dirty", id), 64'(bus.dec_dirty_o), 64'(v.e_dirty));
            chk($sformatf("v%0d shared", id), 64'(bus.dec_shared_o), 64'(v.e_shared));
            chk($sformatf("v%0d err", id), 64'(bus.dec_err_o), 64'(v.e_err));
        end
        cyc();
        chk($sformatf("v%0d busy_after", id), 64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   k;
        int   n;
        int   order[5];

        // port, trs, addr, cr{p3,p2,p1,p0}, e_snp, e_type, e_lat, from, src, dirty, shared, err
        vecs[0] = '{1, 3'd2, 64'h80, {5'b00000, 5'b00000, 5'b00000, 5'b00000},
                    4'b1101, 4'b0001, 3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 3'd3, 64'h1000, {5'b00001, 5'b00101, 5'b00000, 5'b00000},
                    4'b1110, 4'b0111, 3, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{3, 3'd6, 64'hDEAD_BEEF_0000_0040, {5'b11111, 5'b11111, 5'b11111, 5'b11111},
                    4'b0000, 4'b0000, 1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2, 3'd1, 64'h40, {5'b00011, 5'b11111, 5'b00010, 5'b01000},
                    4'b1011, 4'b0000, 3, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{3, 3'd4, 64'hFFFF_FFFF_FFFF_FFC0, {5'b11111, 5'b00000, 5'b00101, 5'b11001},
                    4'b0111, 4'b1001, 3, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1, 3'd7, 64'h2000, {5'b00000, 5'b00001, 5'b00000, 5'b00001},
                    4'b1101, 4'b1001, 3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{0, 3'd0, 64'h3000, {5'b11111, 5'b11111, 5'b11111, 5'b11111},
                    4'b0000, 4'b0000, 1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2, 3'd5, 64'h4000, {5'b11111, 5'b11111, 5'b11111, 5'b11111},
                    4'b0000, 4'b0000, 1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

        bus.req_valid_i = 4'b1111;
        bus.req_trs_i   = '0;
        bus.req_addr_i  = '0;
        bus.snp_ready_i = 4'b1111;
        bus.cr_valid_i  = 4'b1111;
        bus.cr_resp_i   = '0;
        bus.dec_ready_i = 1'b1;
        #2;
        chk("rst req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst busy", 64'(bus.busy_o), 64'd0);
        chk("rst dec_valid", 64'(bus.dec_valid_o), 64'd0);
        chk("rst snp_valid", 64'(bus.snp_valid_o), 64'd0);
        chk("rst cr_ready", 64'(bus.cr_ready_o), 64'd0);
        chk("rst dec_addr", bus.dec_addr_o, 64'd0);
        bus.req_valid_i = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Round-robin with every port requesting write-backs continuously.
        order = '{0, 1, 2, 3, 0};
        for (int p = 0; p < 4; p++) begin
            bus.req_trs_i[p]  = 3'd6;
            bus.req_addr_i[p] = 64'(p * 64);
        end
        bus.req_valid_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk($sformatf("rr%0d req_ready", g), 64'(bus.req_ready_o), 64'(4'b0001 << order[g]));
            @(posedge clk);
            cyc();
            chk($sformatf("rr%0d dec_valid", g), 64'(bus.dec_valid_o), 64'd1);
            chk($sformatf("rr%0d dec_idx", g), 64'(bus.dec_idx_o), 64'(order[g]));
            chk($sformatf("rr%0d ready_held", g), 64'(bus.req_ready_o), 64'd0);
            if (g == 4) bus.req_valid_i = '0;
            cyc();
        end

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Port 0 READ_SHARED with the AC channel of port 2 stalled for five cycles.
        bus.cr_resp_i     = '0;
        bus.snp_ready_i   = 4'b1011;
        bus.req_trs_i[0]  = 3'd2;
        bus.req_addr_i[0] = 64'h5000;
        bus.req_valid_i   = 4'b0001;
        #1;
        chk("stall req_ready", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            chk($sformatf("stall c%0d snp_valid", c), 64'(bus.snp_valid_o),
                64'((c == 1) ? 4'b1110 : 4'b0100));
            chk($sformatf("stall c%0d cr_ready2", c), 64'(bus.cr_ready_o[2]), 64'd0);
            chk($sformatf("stall c%0d dec_valid", c), 64'(bus.dec_valid_o), 64'd0);
        end
        cyc();
        bus.snp_ready_i = 4'b1111;
        #1;
        chk("stall c6 snp_valid", 64'(bus.snp_valid_o), 64'(4'b0100));
        chk("stall c6 cr_ready", 64'(bus.cr_ready_o), 64'd0);
        cyc();
        chk("stall c7 cr_ready", 64'(bus.cr_ready_o), 64'(4'b0100));
        chk("stall c7 dec_valid", 64'(bus.dec_valid_o), 64'd0);
        n = 7;
        k = 0;
        while (n < 20 && k == 0) begin
            cyc();
            n++;
            if (bus.dec_valid_o) k = 1;
        end
        chk("stall latency", 64'(n), 64'd8);
        chk("stall dec_idx", 64'(bus.dec_idx_o), 64'd0);
        chk("stall from_snp", 64'(bus.dec_from_snp_o), 64'd0);
        cyc();

        // Reset asserted while port 1 waits in SNOOP.
        bus.snp_ready_i   = 4'b0000;
        bus.req_trs_i[1]  = 3'd2;
        bus.req_addr_i[1] = 64'h6000;
        bus.req_valid_i   = 4'b0010;
        #1;
        chk("rsnp req_ready", 64'(bus.req_ready_o), 64'(4'b0010));
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        cyc();
        chk("rsnp busy", 64'(bus.busy_o), 64'd1);
        chk("rsnp snp_valid", 64'(bus.snp_valid_o), 64'(4'b1101));
        bus.req_valid_i = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("rsnp snp_drop", 64'(bus.snp_valid_o), 64'd0);
        chk("rsnp busy_drop", 64'(bus.busy_o), 64'd0);
        chk("rsnp req_ready_drop", 64'(bus.req_ready_o), 64'd0);
        chk("rsnp dec_valid_drop", 64'(bus.dec_valid_o), 64'd0);
        cyc();
        cyc();
        bus.req_valid_i = '0;
        bus.snp_ready_i = 4'b1111;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("rsnp idle%0d dec_valid", c), 64'(bus.dec_valid_o), 64'd0);
            chk($sformatf("rsnp idle%0d busy", c), 64'(bus.busy_o), 64'd0);
        end
        for (int p = 0; p < 4; p++) bus.req_trs_i[p] = 3'd6;
        bus.req_valid_i = 4'b1010;
        #1;
        chk("rsnp ptr_reset", 64'(bus.req_ready_o), 64'(4'b0010));
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        cyc();
        chk("rsnp post dec_valid", 64'(bus.dec_valid_o), 64'd1);
        chk("rsnp post dec_idx", 64'(bus.dec_idx_o), 64'd1);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
